// File: rtl/cache_arbiter.sv
// Round-robin owner of the single cache port; grant held until c_done, then RELEASE+IDLE gap.
// c_* follow the granted requester combinationally; a watchdog force-releases hung grants.
module cache_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [NUM_REQ-1:0]      req_w_en,
  input  logic [NUM_REQ-1:0]      req_r_en,
  input  logic [NUM_REQ-1:0]      req_write_through,
  input  logic [NUM_REQ-1:0]      req_read_through,
  input  logic [NUM_REQ*24-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_data_store,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [31:0]             req_data_load,
  output logic                    c_w_en,
  output logic                    c_r_en,
  output logic                    c_write_through,
  output logic                    c_read_through,
  output logic [23:0]             c_addr,
  output logic [31:0]             c_data_store,
  input  logic [31:0]             c_data_load,
  input  logic                    c_done,
  output logic [NUM_REQ-1:0]      timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   g, g_nxt, last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] terr_nxt;
  logic [NUM_REQ-1:0] active;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick;

  assign active = req_w_en | req_r_en;

  // Descending scan so the nearest index after 'last' is the one that sticks.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (active[idx]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      g           <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      timeout_err <= '0;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      last        <= last_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    int gi;
    gi              = int'(g);
    state_nxt       = state;
    g_nxt           = g;
    last_nxt        = last;
    cnt_nxt         = cnt;
    terr_nxt        = timeout_err;
    req_grant       = '0;
    req_done        = '0;
    req_data_load   = '0;
    c_w_en          = 1'b0;
    c_r_en          = 1'b0;
    c_write_through = 1'b0;
    c_read_through  = 1'b0;
    c_addr          = '0;
    c_data_store    = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_vld) begin
          g_nxt     = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        req_grant[gi]   = 1'b1;
        c_w_en          = req_w_en[gi];
        c_r_en          = req_r_en[gi] & ~req_w_en[gi];
        c_write_through = req_write_through[gi];
        c_read_through  = req_read_through[gi];
        c_addr          = req_addr[gi*24 +: 24];
        c_data_store    = req_data_store[gi*32 +: 32];
        cnt_nxt         = cnt + 1'b1;
        if (c_done) begin
          req_done[gi]  = 1'b1;
          req_data_load = c_data_load;
          last_nxt      = g;
          state_nxt     = RELEASE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          terr_nxt[gi]  = 1'b1;
          last_nxt      = g;
          state_nxt     = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
